// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the Simple MIPS CPU: sequences fetch, decode,
// execute, memory and write-back over the shared ALU and unified memory.
module mc_ctrl #(
  parameter int CNT_W           = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_zero,
  output logic [2:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,  S_IF   = 4'd1,  S_ID   = 4'd2,  S_EX_R = 4'd3,
    S_WB_R = 4'd4,  S_EX_I = 4'd5,  S_WB_I = 4'd6,  S_MA   = 4'd7,
    S_MR   = 4'd8,  S_WB_M = 4'd9,  S_MW   = 4'd10, S_BR   = 4'd11,
    S_JMP  = 4'd12, S_HALT = 4'd13
  } state_t;

  typedef enum logic [2:0] {
    C_R = 3'd0, C_I = 3'd1, C_LW = 3'd2, C_SW = 3'd3,
    C_BR = 3'd4, C_J = 3'd5, C_ILL = 3'd6
  } cls_t;

  typedef struct packed {
    cls_t       cls;
    logic [2:0] alu_op;
    logic       ext_zero;
  } dec_t;

  localparam logic [2:0] ALU_NOP  = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_XOR  = 3'd5;
  localparam logic [2:0] ALU_NOR  = 3'd6;
  localparam logic [2:0] ALU_BGTZ = 3'd7;

  // Instruction class, ALU operation and immediate extension for one IR.
  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    d.cls      = C_ILL;
    d.alu_op   = ALU_NOP;
    d.ext_zero = 1'b0;
    case (op)
      6'h00: begin
        case (fn)
          6'h20, 6'h21: begin d.cls = C_R; d.alu_op = ALU_ADD; end
          6'h22, 6'h23: begin d.cls = C_R; d.alu_op = ALU_SUB; end
          6'h24:        begin d.cls = C_R; d.alu_op = ALU_AND; end
          6'h25:        begin d.cls = C_R; d.alu_op = ALU_OR;  end
          6'h26:        begin d.cls = C_R; d.alu_op = ALU_XOR; end
          6'h27:        begin d.cls = C_R; d.alu_op = ALU_NOR; end
          default:      d.cls = C_ILL;
        endcase
      end
      6'h08:   begin d.cls = C_I;  d.alu_op = ALU_ADD; end
      6'h0C:   begin d.cls = C_I;  d.alu_op = ALU_AND; d.ext_zero = 1'b1; end
      6'h0D:   begin d.cls = C_I;  d.alu_op = ALU_OR;  d.ext_zero = 1'b1; end
      6'h0E:   begin d.cls = C_I;  d.alu_op = ALU_XOR; d.ext_zero = 1'b1; end
      6'h23:   begin d.cls = C_LW; d.alu_op = ALU_ADD; end
      6'h2B:   begin d.cls = C_SW; d.alu_op = ALU_ADD; end
      6'h04:   begin d.cls = C_BR; d.alu_op = ALU_SUB; end
      6'h07:   begin d.cls = C_BR; d.alu_op = ALU_BGTZ; end
      6'h02:   d.cls = C_J;
      default: d.cls = C_ILL;
    endcase
    return d;
  endfunction

  state_t           state_r;
  state_t           next_s;
  dec_t             dec_r;
  dec_t             dec_s;
  logic [CNT_W-1:0] cnt_r;
  logic             cnt_inc_s;

  logic             mem_req_s, mem_we_s, iord_s, ir_write_s, pc_write_s;
  logic [1:0]       pc_src_s, alu_src_b_s;
  logic             alu_src_a_s, ext_zero_s, reg_write_s, reg_dst_s;
  logic             mem_to_reg_s, illegal_s;
  logic [2:0]       alu_op_s;

  assign dec_s = decode(opcode, funct);

  // State, retired count and the decode latched in ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_RST;
      cnt_r   <= '0;
      dec_r   <= '0;
    end else begin
      state_r <= next_s;
      if (cnt_inc_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (state_r == S_ID) begin
        dec_r <= dec_s;
      end
    end
  end

  // Next-state and state-decoded control outputs.
  always_comb begin
    next_s       = state_r;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    iord_s       = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    pc_src_s     = 2'd0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'd0;
    ext_zero_s   = 1'b0;
    alu_op_s     = ALU_NOP;
    reg_write_s  = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    illegal_s    = 1'b0;
    case (state_r)
      S_RST: next_s = S_IF;
      S_IF: begin
        mem_req_s   = 1'b1;
        alu_src_b_s = 2'd1;
        alu_op_s    = ALU_ADD;
        if (mem_ack) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          next_s     = S_ID;
        end else begin
          next_s = S_IF;
        end
      end
      S_ID: begin
        alu_src_b_s = 2'd3;
        alu_op_s    = ALU_ADD;
        case (dec_s.cls)
          C_R:        next_s = S_EX_R;
          C_I:        next_s = S_EX_I;
          C_LW, C_SW: next_s = S_MA;
          C_BR:       next_s = S_BR;
          C_J:        next_s = S_JMP;
          default:    next_s = HALT_ON_ILLEGAL ? S_HALT : S_IF;
        endcase
      end
      S_EX_R: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = dec_r.alu_op;
        next_s      = S_WB_R;
      end
      S_WB_R: begin
        reg_write_s = 1'b1;
        reg_dst_s   = 1'b1;
        next_s      = S_IF;
      end
      S_EX_I: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'd2;
        ext_zero_s  = dec_r.ext_zero;
        alu_op_s    = dec_r.alu_op;
        next_s      = S_WB_I;
      end
      S_WB_I: begin
        reg_write_s = 1'b1;
        next_s      = S_IF;
      end
      S_MA: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'd2;
        alu_op_s    = ALU_ADD;
        if (dec_r.cls == C_LW) begin
          next_s = S_MR;
        end else begin
          next_s = S_MW;
        end
      end
      S_MR: begin
        iord_s    = 1'b1;
        mem_req_s = 1'b1;
        if (mem_ack) begin
          next_s = S_WB_M;
        end else begin
          next_s = S_MR;
        end
      end
      S_WB_M: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        next_s       = S_IF;
      end
      S_MW: begin
        iord_s    = 1'b1;
        mem_req_s = 1'b1;
        mem_we_s  = 1'b1;
        if (mem_ack) begin
          next_s = S_IF;
        end else begin
          next_s = S_MW;
        end
      end
      S_BR: begin
        // bgtz relies on the ALU producing 0 when rs > 0
        alu_src_a_s = 1'b1;
        alu_op_s    = dec_r.alu_op;
        pc_src_s    = 2'd1;
        pc_write_s  = zero;
        next_s      = S_IF;
      end
      S_JMP: begin
        pc_src_s   = 2'd2;
        pc_write_s = 1'b1;
        next_s     = S_IF;
      end
      S_HALT: begin
        illegal_s = 1'b1;
        next_s    = S_HALT;
      end
      default: next_s = S_HALT;
    endcase
  end

  // IF->IF stalls are not retirements; only arrival from a later state counts.
  assign cnt_inc_s = (state_r != S_RST) && (state_r != S_IF) && (next_s == S_IF);

  // A reset cycle aborts the instruction, so architectural writes are blocked.
  assign ir_write   = ir_write_s  & ~rst;
  assign pc_write   = pc_write_s  & ~rst;
  assign reg_write  = reg_write_s & ~rst;
  assign mem_req    = mem_req_s;
  assign mem_we     = mem_we_s;
  assign iord       = iord_s;
  assign pc_src     = pc_src_s;
  assign alu_src_a  = alu_src_a_s;
  assign alu_src_b  = alu_src_b_s;
  assign ext_zero   = ext_zero_s;
  assign alu_op     = alu_op_s;
  assign reg_dst    = reg_dst_s;
  assign mem_to_reg = mem_to_reg_s;
  assign illegal    = illegal_s;
  assign state      = state_r;
  assign instr_cnt  = cnt_r;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction cycle scripts built from the
// instruction-level behaviour, with randomized waits, inputs and aborts.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0]  pc_src, alu_src_b;
  logic        alu_src_a, ext_zero, reg_write, reg_dst, mem_to_reg, illegal;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] instr_cnt;

  int          total = 0;
  int          passed = 0;
  logic [31:0] model_cnt = 32'd0;

  typedef struct packed {
    logic [3:0] st;
    logic       mreq, mwe, iord, irw, pcw;
    logic [1:0] pcs;
    logic       asa;
    logic [1:0] asb;
    logic       ez;
    logic [2:0] aop;
    logic       rw, rd, m2r, ill;
  } exp_t;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BGTZ = 5, K_J = 6, K_ILL = 7;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
    .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .state(state),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t sample();
    return {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
            alu_src_b, ext_zero, alu_op, reg_write, reg_dst, mem_to_reg, illegal};
  endfunction

  function automatic exp_t blank(input logic [3:0] s);
    exp_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  // Instruction table: kind, ALU operation in its execute step, zero-extension.
  task automatic ref_decode(input logic [5:0] op, input logic [5:0] fn,
                            output int kind, output logic [2:0] aop, output logic ez);
    kind = K_ILL; aop = 3'd0; ez = 1'b0;
    case (op)
      6'h00: begin
        if (fn >= 6'h20 && fn <= 6'h27) begin
          kind = K_R;
          case (fn)
            6'h20, 6'h21: aop = 3'd1;
            6'h22, 6'h23: aop = 3'd2;
            6'h24: aop = 3'd3;
            6'h25: aop = 3'd4;
            6'h26: aop = 3'd5;
            default: aop = 3'd6;
          endcase
        end
      end
      6'h08: begin kind = K_I; aop = 3'd1; end
      6'h0C: begin kind = K_I; aop = 3'd3; ez = 1'b1; end
      6'h0D: begin kind = K_I; aop = 3'd4; ez = 1'b1; end
      6'h0E: begin kind = K_I; aop = 3'd5; ez = 1'b1; end
      6'h23: kind = K_LW;
      6'h2B: kind = K_SW;
      6'h04: begin kind = K_BEQ; aop = 3'd2; end
      6'h07: begin kind = K_BGTZ; aop = 3'd7; end
      6'h02: kind = K_J;
      default: kind = K_ILL;
    endcase
  endtask

  // Runs one instruction from IF; abort_at >= 0 asserts rst in that cycle.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int if_wait, input int mem_wait, input logic zv,
                           input int abort_at);
    exp_t eq[$];
    int   aq[$];
    bit   idq[$];
    exp_t e;
    int   kind;
    logic [2:0] aop;
    logic ez;
    bit   aborted = 1'b0;
    ref_decode(op, fn, kind, aop, ez);
    for (int i = 0; i <= if_wait; i++) begin
      e = blank(4'd1); e.mreq = 1'b1; e.asb = 2'd1; e.aop = 3'd1;
      if (i == if_wait) begin e.irw = 1'b1; e.pcw = 1'b1; end
      eq.push_back(e); aq.push_back(i == if_wait ? 1 : 0); idq.push_back(1'b0);
    end
    e = blank(4'd2); e.asb = 2'd3; e.aop = 3'd1;
    eq.push_back(e); aq.push_back(2); idq.push_back(1'b1);
    case (kind)
      K_R: begin
        e = blank(4'd3); e.asa = 1'b1; e.aop = aop; eq.push_back(e);
        e = blank(4'd4); e.rw = 1'b1; e.rd = 1'b1; eq.push_back(e);
      end
      K_I: begin
        e = blank(4'd5); e.asa = 1'b1; e.asb = 2'd2; e.ez = ez; e.aop = aop; eq.push_back(e);
        e = blank(4'd6); e.rw = 1'b1; eq.push_back(e);
      end
      K_LW, K_SW: begin
        e = blank(4'd7); e.asa = 1'b1; e.asb = 2'd2; e.aop = 3'd1; eq.push_back(e);
        aq.push_back(2); idq.push_back(1'b0);
        for (int j = 0; j <= mem_wait; j++) begin
          e = blank(kind == K_LW ? 4'd8 : 4'd10); e.mreq = 1'b1; e.iord = 1'b1;
          e.mwe = (kind == K_SW);
          eq.push_back(e); aq.push_back(j == mem_wait ? 1 : 0); idq.push_back(1'b0);
        end
        if (kind == K_LW) begin
          e = blank(4'd9); e.rw = 1'b1; e.m2r = 1'b1; eq.push_back(e);
        end
      end
      K_BEQ, K_BGTZ: begin
        e = blank(4'd11); e.asa = 1'b1; e.aop = aop; e.pcs = 2'd1; e.pcw = zv; eq.push_back(e);
      end
      K_J: begin
        e = blank(4'd12); e.pcs = 2'd2; e.pcw = 1'b1; eq.push_back(e);
      end
      default: for (int j = 0; j < 10; j++) begin
        e = blank(4'd13); e.ill = 1'b1; eq.push_back(e);
      end
    endcase
    while (aq.size() < eq.size()) begin aq.push_back(2); idq.push_back(1'b0); end
    for (int i = 0; i < eq.size(); i++) begin
      @(negedge clk);
      opcode  = idq[i] ? op : 6'($urandom);
      funct   = idq[i] ? fn : 6'($urandom);
      zero    = (eq[i].st == 4'd11) ? zv : 1'($urandom);
      mem_ack = (aq[i] == 2) ? 1'($urandom) : (aq[i] == 1);
      e = eq[i];
      if (i == abort_at) begin
        rst = 1'b1; e.irw = 1'b0; e.pcw = 1'b0; e.rw = 1'b0;
      end
      #1;
      total++;
      if (sample() !== e)
        $display("FAIL %s cyc%0d outputs got=%h (st=%0d) exp=%h (st=%0d)",
                 name, i, sample(), state, e, e.st);
      else passed++;
      if (i == 0) begin
        total++;
        if (instr_cnt !== model_cnt)
          $display("FAIL %s instr_cnt got=%0d exp=%0d", name, instr_cnt, model_cnt);
        else passed++;
      end
      if (i == abort_at) begin aborted = 1'b1; break; end
    end
    if (aborted) begin
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      model_cnt = 32'd0;
      total++;
      if (sample() !== blank(4'd0) || instr_cnt !== 32'd0)
        $display("FAIL %s abort_rst got=%h cnt=%0d exp=%h cnt=0", name, sample(), instr_cnt, blank(4'd0));
      else passed++;
      rst = 1'b0;
    end else if (kind != K_ILL) begin
      model_cnt++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; mem_ack = 1'($urandom); zero = 1'($urandom); opcode = 6'($urandom);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      total++;
      if (sample() !== blank(4'd0) || instr_cnt !== 32'd0)
        $display("FAIL reset_hold got=%h cnt=%0d exp=%h cnt=0", sample(), instr_cnt, blank(4'd0));
      else passed++;
    end
    rst = 1'b0; mem_ack = 1'b0;
    #1;
    total++;
    if (sample() !== blank(4'd0))
      $display("FAIL reset_release got=%h exp=%h", sample(), blank(4'd0));
    else passed++;
    @(negedge clk); #1;
    total++;
    if (state !== 4'd1 || mem_req !== 1'b1 || ir_write !== 1'b0 || instr_cnt !== 32'd0)
      $display("FAIL reset_to_if got st=%0d req=%b irw=%b cnt=%0d exp st=1 req=1 irw=0 cnt=0",
               state, mem_req, ir_write, instr_cnt);
    else passed++;
    model_cnt = 32'd0;
  endtask

  task automatic test_add();
    run_instr("add", 6'h00, 6'h20, 3, 0, 1'($urandom), -1);
  endtask

  task automatic test_sw();
    run_instr("sw", 6'h2B, 6'($urandom), 0, 2, 1'($urandom), -1);
  endtask

  task automatic test_bgtz();
    run_instr("bgtz_z1", 6'h07, 6'($urandom), 1, 0, 1'b1, -1);
    run_instr("bgtz_z0", 6'h07, 6'($urandom), 0, 0, 1'b0, -1);
  endtask

  task automatic test_ori();
    run_instr("ori", 6'h0D, 6'($urandom), 0, 0, 1'($urandom), -1);
  endtask

  task automatic test_rst_mid_mr();
    // cycles: IF(ack), ID, MA, MR wait, MR wait <- reset here
    run_instr("rst_mid_mr", 6'h23, 6'($urandom), 0, 3, 1'($urandom), 4);
    run_instr("after_abort", 6'h08, 6'($urandom), 1, 0, 1'($urandom), -1);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[10] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h07, 6'h02};
    logic [5:0] op, fn;
    int ab;
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 9)];
      fn = (op == 6'h00) ? 6'(6'h20 + $urandom_range(0, 7)) : 6'($urandom);
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 8) : -1;
      run_instr("rand", op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), ab);
    end
  endtask

  task automatic test_illegal();
    run_instr("illegal_op", 6'h3F, 6'($urandom), 0, 0, 1'($urandom), -1);
    test_reset();
    run_instr("illegal_funct", 6'h00, 6'h3A, 2, 0, 1'($urandom), -1);
    test_reset();
    run_instr("post_halt", 6'h02, 6'($urandom), 0, 0, 1'($urandom), -1);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sw();
    test_bgtz();
    test_ori();
    test_rst_mid_mr();
    test_back_to_back();
    test_illegal();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the Simple MIPS CPU.
- Sequences the shared 32-bit ALU, register file, PC/IR registers and unified instruction/data memory over multiple cycles per instruction.
- Drives the 3-bit ALU op code and all datapath selects; consumes opcode/funct and the ALU zero flag.
- Sits between the IR and the datapath muxes; one instance per CPU.

Parameters:
- CNT_W, 32: width of the retired-instruction counter.
- HALT_ON_ILLEGAL, 1: 1 = an illegal opcode/funct enters HALT until reset; 0 = it is treated as NOP and the FSM returns to IF.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag (1 when ALU result == 0).
- mem_ack  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe (valid with mem_req).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut register.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC.
- pc_src  out  2  next-PC select: 0 = ALU result, 1 = ALUOut register, 2 = jump target {PC[31:28], IR[25:0], 2'b00}.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B select: 0 = rt, 1 = constant 4, 2 = extended imm, 3 = sign-extended imm<<2.
- ext_zero  out  1  imm extension: 1 = zero-extend, 0 = sign-extend.
- alu_op  out  3  0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOR, 7 BGTZ.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  destination: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-back source: 0 = ALUOut, 1 = MDR.
- illegal  out  1  1 while in HALT.
- state  out  4  current state, for debug.
- instr_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high.
- Reset: on rst=1 at a clock edge, state <= RST (0) and instr_cnt <= 0.
  - In RST every control output is 0; alu_op = NOP.
  - RST always advances to IF on the next cycle.
  - rst asserted in any state, including mid memory wait, aborts the instruction. No pc_write or reg_write occurs in that cycle.
- Outputs are decoded from state. Exceptions, gated combinationally in the same cycle: ir_write and pc_write in IF are gated by mem_ack; pc_write in BR is gated by zero.
- States (encoding in brackets) and their actions:
  - IF[1]: iord=0, mem_req=1. Holds while mem_ack=0. On mem_ack=1: ir_write=1, pc_write=1, pc_src=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, then go to ID.
  - ID[2]: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target latched into ALUOut). Decode:
    - R-type (op 0x00) with funct 0x20/0x21 -> ADD, 0x22/0x23 -> SUB, 0x24 -> AND, 0x25 -> OR, 0x26 -> XOR, 0x27 -> NOR: go to EX_R.
    - addi 0x08, andi 0x0C, ori 0x0D, xori 0x0E: go to EX_I.
    - lw 0x23, sw 0x2B: go to MA.
    - beq 0x04, bgtz 0x07: go to BR.
    - j 0x02: go to JMP.
    - Anything else: go to HALT if HALT_ON_ILLEGAL, else go to IF and count the instruction as retired.
  - EX_R[3]: alu_src_a=1, alu_src_b=0, alu_op from funct -> WB_R[4].
  - WB_R[4]: reg_write=1, reg_dst=1, mem_to_reg=0 -> IF.
  - EX_I[5]: alu_src_a=1, alu_src_b=2. ext_zero=1 for andi/ori/xori, 0 for addi. alu_op = ADD/AND/OR/XOR respectively -> WB_I[6].
  - WB_I[6]: reg_write=1, reg_dst=0, mem_to_reg=0 -> IF.
  - MA[7]: alu_src_a=1, alu_src_b=2, ext_zero=0, alu_op=ADD -> MR (lw) or MW (sw).
  - MR[8]: iord=1, mem_req=1. Holds until mem_ack -> WB_M.
  - WB_M[9]: reg_write=1, reg_dst=0, mem_to_reg=1 -> IF.
  - MW[10]: iord=1, mem_req=1, mem_we=1. Holds until mem_ack -> IF.
  - BR[11]: alu_src_a=1, alu_src_b=0. alu_op = SUB for beq, BGTZ for bgtz (ALU result is 0 when rs > 0). pc_src=1; pc_write = zero. -> IF.
  - JMP[12]: pc_src=2, pc_write=1 -> IF.
  - HALT[13]: illegal=1, all other outputs 0. Exits only via rst.
- instr_cnt increments by 1 on every transition into IF from a non-RST state. It wraps modulo 2^CNT_W.
- The opcode/funct decode is registered in ID into an internal alu_op/class register. Later states use the registered value, not live IR bits.
- Unused state encodings (14, 15) go to HALT.

Test Plan:
- rst=1 for 2 cycles, then 0 -> all outputs 0 in RST; IF entered 1 cycle after release; instr_cnt=0.
- IR = add (op 0, funct 0x20), mem_ack after 3 wait cycles -> IF held 4 cycles with mem_req=1; then ID, EX_R (alu_op=1, alu_src_b=0), WB_R (reg_write=1, reg_dst=1); instr_cnt=1.
- sw (0x2B) with mem_ack delayed 2 cycles -> MA (alu_op=1), then MW with mem_req=mem_we=iord=1 for 3 cycles; no reg_write at any point.
- bgtz (0x07), zero=1 then repeated with zero=0 -> BR alu_op=7; pc_write=1, pc_src=1 in the first case; pc_write=0 in the second.
- ori (0x0D) -> EX_I alu_op=4, ext_zero=1, alu_src_b=2; WB_I reg_dst=0.
- Opcode 0x3F with HALT_ON_ILLEGAL=1 -> HALT, illegal=1 held 10 cycles; rst -> RST. rst asserted during an MR wait -> RST next cycle, no reg_write.
